// File: rtl/intc_pkg.sv
// Shared constants for the interrupt controller: register offsets, FSM states
// and the lowest-index priority picker.
package intc_pkg;

    localparam int MAX_IRQ = 4;

    localparam logic [2:0] OFF_INT_EN  = 3'd0;
    localparam logic [2:0] OFF_PENDING = 3'd1;
    localparam logic [2:0] OFF_EOI     = 3'd2;
    localparam logic [2:0] OFF_ACTIVE  = 3'd3;
    localparam logic [2:0] OFF_VEC0    = 3'd4;

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } intc_state_e;

    function automatic logic [1:0] lowest_idx(input logic [MAX_IRQ-1:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = MAX_IRQ - 1; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Rising-edge pulse for one interrupt line. Define INTC_IRQ_SYNC_EN to insert a
// two-flop synchroniser ahead of the edge detector for asynchronous sources.
module irq_edge_detect (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_irq,
    output logic o_rise
);

    logic w_line;
    logic r_prev;

`ifdef INTC_IRQ_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_irq;
            r_sync2 <= r_sync1;
        end
    end

    assign w_line = r_sync2;
`else
    assign w_line = i_irq;
`endif

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_line;
        end
    end

    assign o_rise = w_line & ~r_prev;

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped, non-nesting interrupt controller: latches irq edges, masks,
// prioritises (lowest index wins) and issues one request per EOI. INTC_IRQ_SYNC_EN
// adds input synchronisers.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int         NUM_IRQ = 4,
    parameter logic [7:0] BASE    = 8'hF0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [7:0]         addr,
    input  logic [7:0]         w_data,
    input  logic               w_en,
    output logic [7:0]         r_data,
    output logic               int_req,
    output logic [7:0]         int_en,
    output logic [7:0]         int_vec
);

    localparam logic [7:0] EN_MASK = 8'((1 << (NUM_IRQ + 1)) - 1);

    logic [7:0]         w_off;
    logic               w_in_win;
    logic [2:0]         w_reg;
    logic               w_wr;
    logic [NUM_IRQ-1:0] w_rise;
    logic [MAX_IRQ-1:0] w_elig;
    logic [1:0]         w_winner;
    logic               w_issue;
    logic [NUM_IRQ-1:0] w_pending_d;

    logic [7:0]         r_int_en;
    logic [NUM_IRQ-1:0] r_pending;
    logic               r_act_valid;
    logic [1:0]         r_act_id;
    logic [7:0]         r_vec [MAX_IRQ];
    logic               r_int_req;
    logic [7:0]         r_int_vec;
    intc_state_e        r_state;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_edge
        irq_edge_detect u_edge (
            .i_clock   (clock),
            .i_reset_n (reset_n),
            .i_irq     (irq[g]),
            .o_rise    (w_rise[g])
        );
    end

    // Window test by subtraction so BASE need not be 8-byte aligned.
    assign w_off    = addr - BASE;
    assign w_in_win = (w_off[7:3] == 5'd0);
    assign w_reg    = w_off[2:0];
    assign w_wr     = w_en & w_in_win;

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_elig[i] = r_pending[i] & r_int_en[i+1] & r_int_en[0];
        end
    end

    assign w_winner = lowest_idx(w_elig);
    assign w_issue  = (r_state == IDLE) && (w_elig != '0);

    // A fresh edge overrides both software clear and issue clear.
    always_comb begin
        w_pending_d = r_pending;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (w_wr && (w_reg == OFF_PENDING) && w_data[i]) w_pending_d[i] = 1'b0;
            if (w_issue && (w_winner == 2'(i))) w_pending_d[i] = 1'b0;
            if (w_rise[i]) w_pending_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_int_en  <= 8'h00;
            r_pending <= '0;
            for (int i = 0; i < MAX_IRQ; i++) r_vec[i] <= 8'h00;
        end else begin
            r_pending <= w_pending_d;
            if (w_wr && (w_reg == OFF_INT_EN)) r_int_en <= w_data & EN_MASK;
            if (w_wr && w_reg[2] && (int'(w_reg[1:0]) < NUM_IRQ)) begin
                r_vec[w_reg[1:0]] <= w_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_int_req   <= 1'b0;
            r_int_vec   <= 8'h00;
            r_act_valid <= 1'b0;
            r_act_id    <= 2'd0;
        end else begin
            r_int_req <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_int_req   <= 1'b1;
                        r_int_vec   <= r_vec[w_winner];
                        r_act_valid <= 1'b1;
                        r_act_id    <= w_winner;
                        r_state     <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (w_wr && (w_reg == OFF_EOI)) begin
                        r_act_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        r_data = 8'h00;
        if (w_in_win) begin
            case (w_reg)
                OFF_INT_EN:  r_data = r_int_en;
                OFF_PENDING: r_data = 8'(r_pending);
                OFF_ACTIVE:  r_data = {r_act_valid, 5'b00000, r_act_id};
                default: begin
                    if (w_reg[2]) r_data = r_vec[w_reg[1:0]];
                end
            endcase
        end
    end

    assign int_req = r_int_req;
    assign int_en  = r_int_en;
    assign int_vec = r_int_vec;

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Memory-mapped interrupt controller sitting directly upstream of the CPU core, driving its `int_req`, `int_en` and `int_vec` inputs. Latches rising edges on up to four external interrupt lines, masks and prioritises them, and issues a single-cycle request carrying a per-source vector address. Holds off further requests until software signals end-of-interrupt (EOI), matching the core's single-level, non-nesting return-address register.

## Interface
Parameters:
- `NUM_IRQ`, 4, number of interrupt sources, legal 1..4
- `BASE`, 8'hF0, base address of the 8-byte register window

Ports:
- `clock`  in  1  system clock, all state on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `irq`  in  NUM_IRQ  interrupt source lines, rising-edge sensitive
- `addr`  in  8  bus address from the CPU data port
- `w_data`  in  8  bus write data
- `w_en`  in  1  bus write strobe, one write per cycle
- `r_data`  out  8  read data, combinational from `addr`; 0 outside window
- `int_req`  out  1  registered one-cycle interrupt request to the CPU
- `int_en`  out  8  registered copy of the INT_EN register
- `int_vec`  out  8  registered vector, valid in the cycle `int_req`=1

## Operation
Registers, at `BASE`+offset:
- +0 INT_EN, R/W: bit0 global enable; bit i (1..NUM_IRQ) unmasks source i-1; unused bits read 0.
- +1 PENDING, R / write-1-to-clear: bit i = source i latched, not yet issued.
- +2 EOI, W: any write ends service; reads 0.
- +3 ACTIVE, R: bit7 = in service, [1:0] = serviced source id; writes ignored.
- +4..+7 VEC0..VEC3, R/W: vector per source; entries at or above NUM_IRQ read 0, ignore writes.

Behaviour:
- Edge detect: `irq[i]` sampled each cycle; 0→1 between consecutive samples sets PENDING[i].
- Eligible = PENDING[i] & INT_EN[i+1] & INT_EN[0]. Lowest index wins.
- FSM IDLE: if any eligible → `int_req`=1 for one cycle, `int_vec`=VEC[winner], clear PENDING[winner], ACTIVE←{1,winner}, go SERVICE.
- FSM SERVICE: no requests; EOI write → clear ACTIVE[7], go IDLE. EOI in IDLE ignored.
- Simultaneous edge and write-1-clear on same bit: edge wins, bit stays set.
- Simultaneous edge on winner in the issue cycle: bit stays set (new pending).
- Disabling INT_EN[0] in SERVICE does not abort service; only EOI exits.
- Masked sources still latch PENDING.
- Reset: all registers, PENDING, ACTIVE, edge samples = 0; `int_req`=0, `int_en`=0, `int_vec`=0; state IDLE. Reset mid-service discards service and pending.

## Timing
- Edge sampled at edge k → PENDING visible after k; `int_req` high in cycle after edge k+1; CPU takes vector at edge k+2.
- Register writes effective after the write edge; an INT_EN write enabling a pending source allows `int_req` in the following cycle.
- EOI at edge j → IDLE after j; earliest next `int_req` after edge j+1.
- `int_en` output tracks INT_EN with zero extra latency (same register).

## Configuration
- `INTC_IRQ_SYNC_EN`: defined → two-flop synchroniser on each `irq` line before edge detect, adding 2 cycles to request latency (`int_req` after edge k+3). Undefined → `irq` assumed synchronous to `clock`, no synchroniser.

## Structure
- Package `intc_pkg`: register offset constants (OFF_INT_EN, OFF_PENDING, OFF_EOI, OFF_ACTIVE, OFF_VEC0), FSM state enum (IDLE, SERVICE), MAX_IRQ=4.
- Sub-module `irq_edge_detect`: per-line optional synchroniser plus rising-edge pulse, one instance per source.

## Test plan
- Write INT_EN=8'h03, VEC0=8'h40; pulse `irq[0]` → `int_req`=1 one cycle, `int_vec`=8'h40, ACTIVE=8'h80, PENDING=0.
- Enable all, VEC1=8'h50, VEC2=8'h60; raise `irq[1]`,`irq[2]` same cycle → vector 8'h50 issued; no request until EOI; after EOI → vector 8'h60.
- INT_EN=8'h01 (sources masked), pulse `irq[3]` → PENDING=8'h08, no `int_req`; write INT_EN=8'h11 → request with VEC3.
- Write PENDING=8'h01 in same cycle as new `irq[0]` edge → PENDING[0] stays 1.
- Assert `reset_n`=0 during SERVICE with PENDING=8'h06 → all outputs 0, ACTIVE=0, PENDING=0, IDLE; held-high `irq` produces no request after reset.
- With `INTC_IRQ_SYNC_EN`, edge sampled at k → `int_req` after edge k+3.
